// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the MEM pipeline stage. Holds the access size
// encodings, the stage FSM state type, and the byte-lane helpers. Both the
// store path and the load path use these helpers.
// No ports (package).

package mem_access_pkg;

  // Access size encodings as they arrive on in_size (2'b11 behaves as word)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Byte enables for a store of the given size at byte offset a.
  // Half accesses look only at a[1]. Word accesses ignore a.
  function automatic logic [3:0] store_be(input logic [1:0] size,
                                          input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // The store data is replicated across all lanes.
  // The byte enables pick which lanes actually land in the RAM.
  function automatic logic [31:0] store_data(input logic [1:0]  size,
                                             input logic [31:0] r2);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{r2[7:0]}};
      SZ_HALF: d = {2{r2[15:0]}};
      default: d = r2;
    endcase
    return d;
  endfunction

  // Selects the addressed lane of a RAM word and sign- or zero-extends it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  a,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: d = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: d = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: d = word;
    endcase
    return d;
  endfunction

  // Natural-alignment check: halves need a[0]=0, words need a[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] a);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if
// Groups the EX->MEM request fields, the stall handshake, and the MEM/WB
// register outputs.
//   master : EX side. Drives in_*, observes stall and out_*.
//   slave  : MEM stage. Consumes in_*, drives stall and out_*.
// Signals:
//   in_valid, in_pc[31:0], in_ir[31:0], in_dst[4:0], in_r[31:0], in_r2[31:0],
//   in_rd, in_wr, in_size[1:0], in_uns
//   stall, out_valid, out_pc[31:0], out_ir[31:0], out_dst[4:0],
//   out_r[31:0], out_d[31:0], out_exc

interface mem_access_if;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_ir;
  logic [4:0]  in_dst;
  logic [31:0] in_r;
  logic [31:0] in_r2;
  logic        in_rd;
  logic        in_wr;
  logic [1:0]  in_size;
  logic        in_uns;

  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_ir;
  logic [4:0]  out_dst;
  logic [31:0] out_r;
  logic [31:0] out_d;
  logic        out_exc;

  modport master (
    output in_valid, in_pc, in_ir, in_dst, in_r, in_r2, in_rd, in_wr,
           in_size, in_uns,
    input  stall, out_valid, out_pc, out_ir, out_dst, out_r, out_d, out_exc
  );

  modport slave (
    input  in_valid, in_pc, in_ir, in_dst, in_r, in_r2, in_rd, in_wr,
           in_size, in_uns,
    output stall, out_valid, out_pc, out_ir, out_dst, out_r, out_d, out_exc
  );
endinterface

// File: rtl/mem_access_ram.sv
// mem_access_ram
// Single-port synchronous data RAM. It is 32 bits wide, with one write enable
// per byte lane and a 1-cycle read latency. The contents are never reset.
// Ports:
//   clk          in   clock, rising edge
//   en           in   access enable. Reads and writes happen only when set.
//   we[3:0]      in   per-byte write enables (qualified by en)
//   addr[AW-1:0] in   word address
//   wdata[31:0]  in   write data
//   rdata[31:0]  out  read data, registered. Holds while en=0.

module mem_access_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // rdata returns the contents from before the write.
  // The stage ignores rdata for stores.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM pipeline stage. It handles byte, half and word loads (signed or
// unsigned) and stores to a local byte-enabled RAM. A programmable number of
// wait states applies, with a stall back to EX. The stage also owns the
// MEM/WB register.
// Parameters:
//   DEPTH_WORDS  RAM depth in words (power of 2). Higher address bits wrap.
//   WAIT_CYCLES  extra wait states per load/store (0..7)
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous reset, active low
//   bus    mem_access_if.slave : in_* request, stall, out_* MEM/WB register
// Optional feature:
//   MEM_MISALIGN_TRAP_EN defined   : misaligned half/word accesses are
//                                    suppressed and reported on out_exc.
//   MEM_MISALIGN_TRAP_EN undefined : out_exc is 0 and low address bits are
//                                    ignored.

module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        mem_op;
  logic        misaligned;
  logic        access;
  logic        fsm_stall;
  logic        ram_en;
  logic        capture;

  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   load_data;

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [4:0]  dst_q;
  logic [31:0] r_q;
  logic [31:0] d_q;

  assign mem_op = bus.in_valid & (bus.in_rd | bus.in_wr);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = mem_op & is_misaligned(bus.in_size, bus.in_r[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign access = mem_op & ~misaligned;

  assign ram_addr  = bus.in_r[AW+1:2];
  assign ram_we    = bus.in_wr ? store_be(bus.in_size, bus.in_r[1:0]) : 4'b0000;
  assign ram_wdata = store_data(bus.in_size, bus.in_r2);
  assign load_data = load_extract(ram_rdata, bus.in_size, bus.in_r[1:0],
                                  bus.in_uns);

  // Next state and stall.
  // The RAM is enabled only in the presentation cycle, so a store is written
  // exactly once however long the wait.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fsm_stall = 1'b0;
    ram_en    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          fsm_stall = 1'b1;
          ram_en    = 1'b1;
          cnt_d     = 3'(WAIT_CYCLES);
          state_d   = ST_WAIT;
        end else begin
          capture = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 3'd0) begin
          fsm_stall = 1'b1;
          cnt_d     = cnt_q - 3'd1;
        end else begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset gates the combinational stall and RAM enable.
  // This keeps a request held on in_* from stalling EX during reset, and stops
  // it from touching the RAM.
  assign bus.stall = fsm_stall & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register.
  // A bubble in IDLE clears out_valid and leaves the rest untouched.
  // Completion from WAIT always produces a valid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      dst_q   <= '0;
      r_q     <= '0;
      d_q     <= '0;
    end else if (capture) begin
      if (state_q == ST_WAIT || bus.in_valid) begin
        valid_q <= 1'b1;
        pc_q    <= bus.in_pc;
        ir_q    <= bus.in_ir;
        dst_q   <= bus.in_dst;
        r_q     <= bus.in_r;
        d_q     <= (state_q == ST_WAIT && bus.in_rd) ? load_data : 32'd0;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic exc_q;

  // Exceptions only come from IDLE, where a misaligned access finishes in one
  // edge without touching the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_q <= 1'b0;
    end else if (capture && (state_q == ST_WAIT || bus.in_valid)) begin
      exc_q <= (state_q == ST_IDLE) & misaligned;
    end
  end

  assign bus.out_exc = exc_q;
`else
  assign bus.out_exc = 1'b0;
`endif

  assign bus.out_valid = valid_q;
  assign bus.out_pc    = pc_q;
  assign bus.out_ir    = ir_q;
  assign bus.out_dst   = dst_q;
  assign bus.out_r     = r_q;
  assign bus.out_d     = d_q;

  mem_access_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en & rst_n),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Self-checking bench for mem_access_stage. It uses DEPTH_WORDS=256 (1 KiB of
// byte space, so addresses wrap at 0x400) and WAIT_CYCLES=3.
// It covers:
//   - reset values
//   - a directed vector table for stores, loads and extension
//   - misalignment handling (follows MEM_MISALIGN_TRAP_EN)
//   - reset during a wait
//   - randomized traffic checked against a byte-array memory model

module tb_mem_access_stage;
  import mem_access_pkg::*;

  localparam int TB_DEPTH = 256;
  localparam int TB_WAIT  = 3;
  localparam int NBYTES   = TB_DEPTH * 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [31:0] last_r;
  logic [7:0]  model_mem [NBYTES];

  mem_access_if bus ();

  mem_access_stage #(
    .DEPTH_WORDS(TB_DEPTH),
    .WAIT_CYCLES(TB_WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_d;
  } vec_t;

  vec_t tbl [14];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int bytes_of(input logic [1:0] size);
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] size, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (bytes_of(size) == 2 && a[0]) || (bytes_of(size) == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Byte address inside the RAM. Upper bits wrap and the alignment bits are
  // dropped for half and word accesses.
  function automatic int model_base(input logic [1:0] size, input logic [31:0] a);
    int b;
    b = int'(a % NBYTES);
    b = b - (b % bytes_of(size));
    return b;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns,
                                             input logic [31:0] a);
    int n;
    int b;
    logic [31:0] v;
    n = bytes_of(size);
    b = model_base(size, a);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(model_mem[b+i]) << (8*i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] a,
                             input logic [31:0] d);
    int n;
    int b;
    n = bytes_of(size);
    b = model_base(size, a);
    for (int i = 0; i < n; i++) model_mem[b+i] = d[8*i +: 8];
  endtask

  // Presents one instruction, waits out the stall, and checks the MEM/WB
  // register right after the capturing edge.
  // The caller supplies the expected out_d.
  task automatic applyStimulus(input bit valid, input bit rd, input bit wr,
                               input logic [1:0] size, input bit uns,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] exp_d);
    int stalls;
    int exp_stalls;
    bit mis;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  dst;
    pc  = $urandom;
    ir  = $urandom;
    dst = 5'($urandom);
    mis = valid && (rd || wr) && model_mis(size, addr);
    exp_stalls = (valid && (rd || wr) && !mis) ? TB_WAIT + 1 : 0;
    bus.in_valid = valid;
    bus.in_pc    = pc;
    bus.in_ir    = ir;
    bus.in_dst   = dst;
    bus.in_r     = addr;
    bus.in_r2    = data;
    bus.in_rd    = rd;
    bus.in_wr    = wr;
    bus.in_size  = size;
    bus.in_uns   = uns;
    stalls = 0;
    @(negedge clk);
    while (bus.stall === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 20) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL stall_timeout: stall still high after %0d cycles, expected low", stalls);
    end
    @(posedge clk);
    #1;
    checkOutput("stall_cycles", 32'(stalls), 32'(exp_stalls));
    if (valid) begin
      checkOutput("out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("out_pc", bus.out_pc, pc);
      checkOutput("out_ir", bus.out_ir, ir);
      checkOutput("out_dst", 32'(bus.out_dst), 32'(dst));
      checkOutput("out_r", bus.out_r, addr);
      checkOutput("out_d", bus.out_d, mis ? 32'd0 : exp_d);
      checkOutput("out_exc", 32'(bus.out_exc), 32'(mis));
      last_r = addr;
      if (wr && !mis) model_store(size, addr, data);
    end else begin
      checkOutput("bubble_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("bubble_hold_r", bus.out_r, last_r);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_pc"}, bus.out_pc, 32'd0);
    checkOutput({tag, "_ir"}, bus.out_ir, 32'd0);
    checkOutput({tag, "_dst"}, 32'(bus.out_dst), 32'd0);
    checkOutput({tag, "_r"}, bus.out_r, 32'd0);
    checkOutput({tag, "_d"}, bus.out_d, 32'd0);
    checkOutput({tag, "_exc"}, 32'(bus.out_exc), 32'd0);
    checkOutput({tag, "_stall"}, 32'(bus.stall), 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    int          kind;
    bit          u;

    n_checks = 0;
    n_fail   = 0;
    last_r   = 32'd0;
    rst_n    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pc    = '0;
    bus.in_ir    = '0;
    bus.in_dst   = '0;
    bus.in_r     = '0;
    bus.in_r2    = '0;
    bus.in_rd    = 1'b0;
    bus.in_wr    = 1'b0;
    bus.in_size  = 2'b10;
    bus.in_uns   = 1'b0;
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;

    // Directed vectors: store, extension, partial stores, wrap, ALU op
    tbl[0]  = '{0, 1, SZ_WORD, 0, 32'h10,  32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1, 0, SZ_BYTE, 0, 32'h13,  32'h0,        32'hFFFFFFDE};
    tbl[3]  = '{1, 0, SZ_BYTE, 1, 32'h13,  32'h0,        32'h000000DE};
    tbl[4]  = '{1, 0, SZ_HALF, 0, 32'h12,  32'h0,        32'hFFFFDEAD};
    tbl[5]  = '{1, 0, SZ_HALF, 1, 32'h10,  32'h0,        32'h0000BEEF};
    tbl[6]  = '{0, 1, SZ_BYTE, 0, 32'h11,  32'hFFFFFF55, 32'h0};
    tbl[7]  = '{1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'hDEAD55EF};
    tbl[8]  = '{0, 1, SZ_HALF, 0, 32'h12,  32'hABCD1234, 32'h0};
    tbl[9]  = '{1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'h123455EF};
    tbl[10] = '{1, 0, SZ_WORD, 0, 32'h410, 32'h0,        32'h123455EF};
    tbl[11] = '{1, 0, SZ_BYTE, 0, 32'h10,  32'h0,        32'hFFFFFFEF};
    tbl[12] = '{1, 0, SZ_HALF, 0, 32'h12,  32'h0,        32'h00001234};
    tbl[13] = '{0, 0, SZ_WORD, 0, 32'hCAFE, 32'h0,       32'h0};

    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].uns,
                    tbl[i].addr, tbl[i].data, tbl[i].exp_d);
    end

    $display("[TB] misaligned accesses");
    // Without the trap, lw @0x12 reads word 0x10 and sw @0x11 writes all of
    // word 0x10. With the trap, both are flagged and the RAM keeps 0x123455EF.
    applyStimulus(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 32'h123455EF);
    applyStimulus(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h11, 32'hA5A5A5A5, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h123455EF);
`else
    applyStimulus(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hA5A5A5A5);
`endif

    $display("[TB] reset during wait");
    bus.in_valid = 1'b1;
    bus.in_rd    = 1'b1;
    bus.in_wr    = 1'b0;
    bus.in_size  = SZ_WORD;
    bus.in_r     = 32'h10;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("wait_stall", 32'(bus.stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midwait_reset");
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    last_r = 32'd0;
    applyStimulus(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,
                  model_load(SZ_WORD, 1'b0, 32'h10));

    $display("[TB] ALU ops with bubbles");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i[0], 1'b0, 1'b0, SZ_WORD, 1'b0, $urandom, $urandom, 32'h0);
    end

    $display("[TB] filling low memory");
    for (int w = 0; w < 16; w++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'(w * 4), $urandom, 32'h0);
    end

    $display("[TB] randomized traffic");
    for (int k = 0; k < 200; k++) begin
      kind = $urandom_range(0, 9);
      sz   = 2'($urandom_range(0, 3));
      u    = 1'($urandom_range(0, 1));
      a    = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a = a | ($urandom & 32'hFFFFFC00);
      d    = $urandom;
      if (kind < 4) begin
        applyStimulus(1'b1, 1'b1, 1'b0, sz, u, a, d, model_load(sz, u, a));
      end else if (kind < 7) begin
        applyStimulus(1'b1, 1'b0, 1'b1, sz, u, a, d, 32'h0);
      end else if (kind < 9) begin
        applyStimulus(1'b1, 1'b0, 1'b0, sz, u, a, d, 32'h0);
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, sz, u, a, d, 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
